// File: rtl/e1of2_channel.sv
// Dual-rail (1-of-2) channel with enable: bundled valid/ready in,
// 4-phase return-to-zero transfer to an internal receiver, bundled out.
module e1of2_channel #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [W-1:0] rail_t,
    output logic [W-1:0] rail_f,
    output logic         rail_e
);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_DATA,
        TX_RTZ
    } tx_t;

    typedef enum logic {
        RX_WAIT,
        RX_NEUTRAL
    } rx_t;

    tx_t          tx_q, tx_d;
    rx_t          rx_q, rx_d;
    logic [W-1:0] rail_t_d, rail_f_d;
    logic         rail_e_d;
    logic         out_valid_d;
    logic [W-1:0] out_data_d;

    logic complete;
    logic neutral;
    logic capture;

    assign in_ready = (tx_q == TX_IDLE) && rail_e;

    // Each bit must carry exactly one high rail before the token is taken.
    assign complete = &(rail_t ^ rail_f);
    assign neutral  = ~|(rail_t | rail_f);
    assign capture  = (rx_q == RX_WAIT) && complete
                    && (!out_valid || out_ready);

    always_comb begin
        tx_d     = tx_q;
        rail_t_d = rail_t;
        rail_f_d = rail_f;
        unique case (tx_q)
            TX_IDLE: begin
                if (in_valid && in_ready) begin
                    rail_t_d = in_data;
                    rail_f_d = ~in_data;
                    tx_d     = TX_DATA;
                end
            end
            TX_DATA: begin
                if (!rail_e) begin
                    rail_t_d = '0;
                    rail_f_d = '0;
                    tx_d     = TX_RTZ;
                end
            end
            TX_RTZ: begin
                if (rail_e) begin
                    tx_d = TX_IDLE;
                end
            end
            default: begin
                rail_t_d = '0;
                rail_f_d = '0;
                tx_d     = TX_IDLE;
            end
        endcase
    end

    always_comb begin
        rx_d        = rx_q;
        rail_e_d    = rail_e;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end
        unique case (rx_q)
            RX_WAIT: begin
                if (capture) begin
                    out_data_d  = rail_t;
                    out_valid_d = 1'b1;
                    rail_e_d    = 1'b0;
                    rx_d        = RX_NEUTRAL;
                end
            end
            RX_NEUTRAL: begin
                if (neutral) begin
                    rail_e_d = 1'b1;
                    rx_d     = RX_WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q      <= TX_IDLE;
            rx_q      <= RX_WAIT;
            rail_t    <= '0;
            rail_f    <= '0;
            rail_e    <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rail_t    <= rail_t_d;
            rail_f    <= rail_f_d;
            rail_e    <= rail_e_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_e1of2_channel.sv
// Bench for e1of2_channel: W=9 and W=1 instances, queue scoreboard
// plus directed timing checks around each handshake phase.
module tb_e1of2_channel;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       iv9 = 1'b0, ir9, ov9, or9 = 1'b1, re9;
    logic [8:0] id9 = '0, od9, rt9, rf9;

    logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b1, re1;
    logic [0:0] id1 = '0, od1, rt1, rf1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pop9  = 0;
    int pop1  = 0;

    logic [8:0] q9[$];
    logic [0:0] q1[$];

    e1of2_channel #(.W(9)) u9 (
        .clk(clk), .reset(reset),
        .in_valid(iv9), .in_data(id9), .in_ready(ir9),
        .out_valid(ov9), .out_data(od9), .out_ready(or9),
        .rail_t(rt9), .rail_f(rf9), .rail_e(re9)
    );

    e1of2_channel #(.W(1)) u1 (
        .clk(clk), .reset(reset),
        .in_valid(iv1), .in_data(id1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ready(or1),
        .rail_t(rt1), .rail_f(rf1), .rail_e(re1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept, pop when the consumer takes a token.
    always @(negedge clk) begin
        if (reset) begin
            q9.delete();
            q1.delete();
        end else begin
            if (iv9 && ir9) q9.push_back(id9);
            if (ov9 && or9) begin
                if (q9.size() == 0) chk("sb9_extra", 1, 0);
                else chk("sb9", od9, q9.pop_front());
                pop9++;
            end
            chk("excl9", rt9 & rf9, 0);
            if (iv1 && ir1) q1.push_back(id1);
            if (ov1 && or1) begin
                if (q1.size() == 0) chk("sb1_extra", 1, 0);
                else chk("sb1", od1, q1.pop_front());
                pop1++;
            end
            chk("excl1", rt1 & rf1, 0);
        end
    end

    task automatic send9(input logic [8:0] d, output int at);
        bit acc;
        acc = 1'b0;
        at  = -1;
        iv9 = 1'b1;
        id9 = d;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = ir9;
            tick();
        end
        if (acc) at = cyc;
        else chk("accept9_timeout", 0, 1);
    endtask

    task automatic send1(input logic [0:0] d);
        bit acc;
        acc = 1'b0;
        iv1 = 1'b1;
        id1 = d;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = ir1;
            tick();
        end
        iv1 = 1'b0;
        if (!acc) chk("accept1_timeout", 0, 1);
    endtask

    task automatic chk_reset9(input string tag);
        chk({tag, "_rt"}, rt9, 0);
        chk({tag, "_rf"}, rf9, 0);
        chk({tag, "_re"}, re9, 1);
        chk({tag, "_ov"}, ov9, 0);
        chk({tag, "_od"}, od9, 0);
        chk({tag, "_ir"}, ir9, 1);
    endtask

    logic [8:0] vals [4];
    int t0;
    int prev;
    int p0;

    initial begin
        vals[0] = 9'h000;
        vals[1] = 9'h1FF;
        vals[2] = 9'h0AA;
        vals[3] = 9'h155;

        // reset state, then reset in the middle of a token
        repeat (2) tick();
        reset = 1'b0;
        chk_reset9("rst");
        chk("rst1_re", re1, 1);
        chk("rst1_ir", ir1, 1);
        send9(9'h0C3, t0);
        iv9 = 1'b0;
        chk("mid_rt", rt9, 9'h0C3);
        tick();
        chk("mid_ov", ov9, 1);
        reset = 1'b1;
        tick();
        chk_reset9("midrst");
        reset = 1'b0;
        tick();

        // single token, phase-by-phase timing
        or9 = 1'b1;
        send9(9'h1A5, t0);
        iv9 = 1'b0;
        id9 = 9'h000;
        chk("t0_rt", rt9, 9'h1A5);
        chk("t0_rf", rf9, 9'h05A);
        chk("t0_ir", ir9, 0);
        chk("t0_ov", ov9, 0);
        tick();
        chk("t1_ov", ov9, 1);
        chk("t1_od", od9, 9'h1A5);
        chk("t1_re", re9, 0);
        chk("t1_rt", rt9, 9'h1A5);
        tick();
        chk("t2_rt", rt9, 0);
        chk("t2_rf", rf9, 0);
        chk("t2_ov", ov9, 0);
        tick();
        chk("t3_re", re9, 1);
        chk("t3_ir", ir9, 0);
        tick();
        chk("t4_ir", ir9, 1);

        // backpressure, then drain and capture on one edge
        or9 = 1'b0;
        send9(9'h0FF, t0);
        iv9 = 1'b0;
        repeat (4) tick();
        chk("bpA_ov", ov9, 1);
        chk("bpA_od", od9, 9'h0FF);
        chk("bpA_ir", ir9, 1);
        send9(9'h100, t0);
        iv9 = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("bp_rt", rt9, 9'h100);
            chk("bp_re", re9, 1);
            chk("bp_od", od9, 9'h0FF);
            chk("bp_ov", ov9, 1);
            chk("bp_ir", ir9, 0);
        end
        or9 = 1'b1;
        tick();
        chk("bpB_ov", ov9, 1);
        chk("bpB_od", od9, 9'h100);
        chk("bpB_re", re9, 0);
        repeat (5) tick();

        // streaming with in_valid held
        p0 = pop9;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            send9(vals[i], t0);
            if (i > 0) chk("stream_gap", t0 - prev, 5);
            prev = t0;
        end
        iv9 = 1'b0;
        repeat (8) tick();
        chk("stream_cnt", pop9 - p0, 4);
        chk("stream_q", q9.size(), 0);

        // single-rail-pair instance
        send1(1'b0);
        chk("w1a_rf", rf1, 1);
        chk("w1a_rt", rt1, 0);
        tick();
        chk("w1a_ov", ov1, 1);
        chk("w1a_od", od1, 0);
        repeat (4) tick();
        send1(1'b1);
        chk("w1b_rt", rt1, 1);
        chk("w1b_rf", rf1, 0);
        tick();
        chk("w1b_ov", ov1, 1);
        chk("w1b_od", od1, 1);
        repeat (5) tick();
        chk("w1_cnt", pop1, 2);

        // long idle
        for (int k = 0; k < 5; k++) begin
            repeat (10) tick();
            chk("idle_rt", rt9, 0);
            chk("idle_rf", rf9, 0);
            chk("idle_re", re9, 1);
            chk("idle_ov", ov9, 0);
            chk("idle_ir", ir9, 1);
        end

        chk("q9_empty", q9.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e1of2_channel.md
Name: e1of2_channel

Overview:
- Synchronous, synthesizable model of the 1-of-2 (dual-rail) channel with enable that links router sub-blocks (decoder → merge, split → arbiter).
- A bundled valid/ready producer port is encoded onto dual-rail wires, and a 4-phase return-to-zero handshake runs against an internal receiver.
- The receiver decodes each token back to bundled valid/ready.
- The router instantiates it as e1of2_9 (W=9, packet data) and e1of2_1 (W=1, select/grant).

Parameters:
W, 9, token width in bits. Instances use 9 and 1; any W ≥ 1 is legal.

Ports:
clk  input  1  single clock; everything updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer offers a token
in_data  input  W  token value
in_ready  output  1  combinational; = (tx state IDLE) && rail_e
out_valid  output  1  registered; decoded token available
out_data  output  W  registered decoded token
out_ready  input  1  consumer accepts the token
rail_t  output  W  registered true rails (observation)
rail_f  output  W  registered false rails (observation)
rail_e  output  1  registered enable from receiver (observation)

Behaviour:
- Reset, synchronous and active-high, clears all state on the next edge, including mid-token:
  - rail_t = 0, rail_f = 0, rail_e = 1
  - out_valid = 0, out_data = 0
  - tx state = IDLE, rx state = WAIT
- Encoding for bit i:
  - rail_t[i] = 1, rail_f[i] = 0 encodes 1.
  - rail_t[i] = 0, rail_f[i] = 1 encodes 0.
  - Both rails 0 is neutral.
  - Both rails 1 is illegal and is never produced.
- Transmitter FSM:
  - IDLE: rails neutral. On in_valid && in_ready, register rail_t = in_data and rail_f = ~in_data, then go to DATA.
  - DATA: hold rails. When rail_e == 0, drive rails to neutral and go to RTZ.
  - RTZ: rails neutral. When rail_e == 1, go to IDLE.
- Receiver FSM:
  - "Complete" means every bit has exactly one rail high.
  - "Neutral" means all rails are 0.
  - WAIT (rail_e = 1): when complete && (!out_valid || out_ready), capture out_data = rail_t, set out_valid = 1, set rail_e = 0, go to NEUTRAL.
  - NEUTRAL (rail_e = 0): when neutral, set rail_e = 1 and go to WAIT.
- Output register:
  - out_valid clears on out_valid && out_ready unless a new capture happens in the same cycle.
  - On a same-cycle drain and capture, out_valid stays 1 and out_data takes the new value.
- Timing, with the accept edge at t0:
  - Rails valid after t0.
  - out_valid = 1 and rail_e = 0 after t0+1.
  - Rails neutral after t0+2.
  - rail_e = 1 after t0+3.
  - in_ready = 1 again after t0+4.
  - Latency from input to output is 2 edges; sustained throughput is 1 token per 5 cycles.
- Backpressure: with out_valid = 1 and out_ready = 0, the receiver does not capture. rail_e stays 1, the transmitter holds DATA with stable rails, and in_ready = 0.
- in_data is sampled only on the accept edge; later changes do not affect the rails.
- W = 1 behaves identically, with a single rail pair.

Test Plan:
1. Reset, then check outputs: rail_t = rail_f = 0, rail_e = 1, out_valid = 0, in_ready = 1. Assert reset mid-token (tx in DATA) → all values return to reset state on the next edge.
2. W=9, send 9'h1A5 with out_ready = 1 → after t0:
   - rail_t = 1A5 and rail_f = 05A.
   - After t0+1: out_valid = 1, out_data = 1A5, rail_e = 0.
   - After t0+2: rails 0.
   - After t0+3: rail_e = 1.
   - After t0+4: in_ready = 1.
3. Backpressure, W=9: token A = 9'h0FF delivered, out_ready = 0, then offer token B = 9'h100 → rails hold t = 100 for N cycles with rail_e = 1 and out_data = 0FF. Raise out_ready → same edge drains A and captures B, out_valid stays 1.
4. Streaming, W=9, in_valid held, sequence 000, 1FF, 0AA, 155 → values delivered in order, one every 5 cycles, no duplication.
5. W=1 instance, send 0 then 1 → rail_f = 1 for the first token and rail_t = 1 for the second. out_data = 0 then 1. Both rails are never high together in any cycle.
6. in_valid = 0 for a long idle period → rails stay neutral, rail_e = 1, out_valid = 0.
